// File: rtl/rsa_job_arbiter_if.sv
// Request, result and rsa_unit-side signals of the job arbiter, bundled for port connection.
// slave is the arbiter's view; master is the requester/unit side driving the job inputs.
interface rsa_job_arbiter_if #(
  parameter int WIDTH = 8
);
  logic               ena;
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [4*WIDTH-1:0] req0_ops;
  logic [4*WIDTH-1:0] req1_ops;
  logic [1:0]         abort;
  logic [1:0]         irq_clr;

  logic               rsa_en;
  logic               rsa_rstb;
  logic [WIDTH-1:0]   rsa_p;
  logic [WIDTH-1:0]   rsa_e;
  logic [WIDTH-1:0]   rsa_m;
  logic [WIDTH-1:0]   rsa_const;
  logic               rsa_eoc;
  logic [WIDTH-1:0]   rsa_c;

  logic [WIDTH-1:0]   res_c;
  logic               res_owner;
  logic [1:0]         res_status;
  logic [1:0]         irq;
  logic               busy;

  modport slave (
    input  ena, req_valid, req0_ops, req1_ops, abort, irq_clr, rsa_eoc, rsa_c,
    output req_ready, rsa_en, rsa_rstb, rsa_p, rsa_e, rsa_m, rsa_const,
           res_c, res_owner, res_status, irq, busy
  );

  modport master (
    output ena, req_valid, req0_ops, req1_ops, abort, irq_clr, rsa_eoc, rsa_c,
    input  req_ready, rsa_en, rsa_rstb, rsa_p, rsa_e, rsa_m, rsa_const,
           res_c, res_owner, res_status, irq, busy
  );
endinterface

// File: rtl/rsa_job_arbiter.sv
// Round-robin owner of the shared rsa_unit: grant in IDLE, LOAD 1 cycle, RUN under watchdog, FLUSH 1 cycle.
// Result/status/irq appear in FLUSH (cycle after exit); req_ready is offered only in IDLE with ena high.
module rsa_job_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1023
) (
  input logic              clk,
  input logic              rstb,
  rsa_job_arbiter_if.slave bus
);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_DONE    = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] cst;
  } ops_t;

  state_t           state;
  state_t           state_nxt;
  logic             owner;
  logic             last_owner;
  logic [TW-1:0]    timer;
  ops_t             ops_q;
  logic [WIDTH-1:0] res_c_q;
  logic             res_owner_q;
  logic [1:0]       res_status_q;
  logic [1:0]       irq_q;

  logic             grant_vld;
  logic             winner;
  logic [1:0]       ready;
  ops_t             win_ops;
  logic             own_abort;
  logic             timeout_hit;
  logic             job_end;
  logic [1:0]       end_status;
  logic [1:0]       irq_set;

  // Arbitration: a lone request wins; on a tie the requester that did not own the last job wins.
  always_comb begin
    grant_vld = 1'b0;
    winner    = 1'b0;
    if (state == IDLE && bus.ena) begin
      case (bus.req_valid)
        2'b01:   begin grant_vld = 1'b1; winner = 1'b0;        end
        2'b10:   begin grant_vld = 1'b1; winner = 1'b1;        end
        2'b11:   begin grant_vld = 1'b1; winner = ~last_owner; end
        default: begin grant_vld = 1'b0; winner = 1'b0;        end
      endcase
    end
    ready   = grant_vld ? (winner ? 2'b10 : 2'b01) : 2'b00;
    win_ops = winner ? ops_t'(bus.req1_ops) : ops_t'(bus.req0_ops);
  end

  // RUN exit with priority abort > eoc > timeout; abort from the non-owner is not looked at.
  always_comb begin
    own_abort   = bus.abort[owner];
    timeout_hit = (timer == TIMER_LAST);
    job_end     = (state == RUN) && (own_abort || bus.rsa_eoc || timeout_hit);
    if (own_abort)        end_status = ST_ABORT;
    else if (bus.rsa_eoc) end_status = ST_DONE;
    else                  end_status = ST_TIMEOUT;
    irq_set = job_end ? (owner ? 2'b10 : 2'b01) : 2'b00;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = LOAD;
      LOAD:    state_nxt = RUN;
      RUN:     if (job_end) state_nxt = FLUSH;
      FLUSH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      ops_q      <= '0;
    end else if (grant_vld) begin
      owner      <= winner;
      last_owner <= winner;
      ops_q      <= win_ops;
    end
  end

  // Saturates at the last count so a stuck RUN can never wrap the watchdog.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                                 timer <= '0;
    else if (state == LOAD)                    timer <= '0;
    else if (state == RUN && !timeout_hit)     timer <= timer + TW'(1);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      res_c_q      <= '0;
      res_owner_q  <= 1'b0;
      res_status_q <= ST_NONE;
    end else if (job_end) begin
      res_owner_q  <= owner;
      res_status_q <= end_status;
      if (end_status == ST_DONE) res_c_q <= bus.rsa_c;
    end
  end

  // Set beats a same-cycle clear.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) irq_q <= 2'b00;
    else       irq_q <= (irq_q & ~bus.irq_clr) | irq_set;
  end

  assign bus.req_ready  = ready;
  assign bus.rsa_en     = (state == RUN);
  assign bus.rsa_rstb   = (state == LOAD) || (state == RUN);
  assign bus.busy       = (state != IDLE);
  assign bus.rsa_p      = ops_q.p;
  assign bus.rsa_e      = ops_q.e;
  assign bus.rsa_m      = ops_q.m;
  assign bus.rsa_const  = ops_q.cst;
  assign bus.res_c      = res_c_q;
  assign bus.res_owner  = res_owner_q;
  assign bus.res_status = res_status_q;
  assign bus.irq        = irq_q;
endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Bench for rsa_job_arbiter: a stub rsa_unit and a job-level model (owner, exit cycle, status, irq) per scenario.
`timescale 1ns/1ps
module tb_rsa_job_arbiter;
  localparam int W  = 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  rsa_job_arbiter_if #(.WIDTH(W)) bus ();
  rsa_job_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (.clk(clk), .rstb(rstb), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic         m_last;
  logic [W-1:0] m_res_c;
  logic         m_res_owner;
  logic [1:0]   m_status;
  logic [1:0]   m_irq;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_model();
    m_last = 1'b1; m_res_c = '0; m_res_owner = 1'b0; m_status = 2'b00; m_irq = 2'b00;
  endtask

  task automatic idle_inputs();
    bus.ena = 1'b1; bus.req_valid = 2'b00; bus.abort = 2'b00; bus.irq_clr = 2'b00;
    bus.rsa_eoc = 1'b0; bus.rsa_c = '0; bus.req0_ops = '0; bus.req1_ops = '0;
  endtask

  // One job from request to return to IDLE. eoc_k/abort_k/oth_k: RUN cycle numbers (1-based), 0 = never.
  task automatic run_job(input string name, input logic [1:0] vld, input logic [4*W-1:0] ops0,
                         input logic [4*W-1:0] ops1, input logic [W-1:0] c, input int eoc_k,
                         input int abort_k, input int oth_k, input logic clr_same, input logic clr_next);
    int w, exit_k, en_cnt, waited;
    logic [1:0] st, exp_rdy;
    logic [4*W-1:0] wops;
    w       = (vld == 2'b11) ? int'(!m_last) : (vld[1] ? 1 : 0);
    exp_rdy = (w == 1) ? 2'b10 : 2'b01;
    wops    = (w == 1) ? ops1 : ops0;
    exit_k  = TO;
    if (eoc_k > 0 && eoc_k < exit_k) exit_k = eoc_k;
    if (abort_k > 0 && abort_k <= exit_k) exit_k = abort_k;
    st = (abort_k == exit_k) ? 2'b10 : ((eoc_k == exit_k) ? 2'b01 : 2'b11);

    bus.req0_ops = ops0; bus.req1_ops = ops1; bus.req_valid = vld;
    #1;
    waited = 0;
    while (bus.req_ready === 2'b00 && waited < 8) begin step(); #1; waited++; end
    total++; if (bus.req_ready !== exp_rdy) begin bad++; $display("FAIL %s grant got=%b want=%b", name, bus.req_ready, exp_rdy); end
    if (bus.req_ready === 2'b00) begin bus.req_valid = 2'b00; return; end

    step();  // LOAD
    bus.req0_ops = (4*W)'($urandom); bus.req1_ops = (4*W)'($urandom);
    bus.ena = 1'($urandom);
    #1;
    total++; if ({bus.rsa_p, bus.rsa_e, bus.rsa_m, bus.rsa_const} !== wops) begin bad++; $display("FAIL %s ops got=%h want=%h", name, {bus.rsa_p, bus.rsa_e, bus.rsa_m, bus.rsa_const}, wops); end
    total++; if ({bus.rsa_rstb, bus.rsa_en, bus.busy, bus.req_ready} !== 5'b10100) begin bad++; $display("FAIL %s load_ctl got=%b want=10100", name, {bus.rsa_rstb, bus.rsa_en, bus.busy, bus.req_ready}); end

    en_cnt = 0;
    for (int k = 1; k <= exit_k; k++) begin
      step();  // RUN cycle k
      bus.rsa_eoc = (k == eoc_k);
      bus.rsa_c   = (k == eoc_k) ? c : W'($urandom);
      bus.abort   = 2'b00;
      if (k == abort_k) bus.abort[w] = 1'b1;
      if (k == oth_k)   bus.abort[1-w] = 1'b1;
      bus.irq_clr = (k == exit_k && clr_same) ? exp_rdy : 2'b00;
      if (bus.rsa_en === 1'b1 && bus.rsa_rstb === 1'b1) en_cnt++;
    end

    step();  // FLUSH
    bus.rsa_eoc = 1'b1; bus.abort = 2'b00; bus.ena = 1'b1;
    bus.irq_clr = clr_next ? exp_rdy : 2'b00;
    m_last = (w == 1); m_res_owner = (w == 1); m_status = st;
    if (st == 2'b01) m_res_c = c;
    m_irq = (m_irq & ~(clr_same ? exp_rdy : 2'b00)) | exp_rdy;
    #1;
    total++; if (en_cnt != exit_k) begin bad++; $display("FAIL %s en_cycles got=%0d want=%0d", name, en_cnt, exit_k); end
    total++; if ({bus.rsa_en, bus.rsa_rstb, bus.busy} !== 3'b001) begin bad++; $display("FAIL %s flush_ctl got=%b want=001", name, {bus.rsa_en, bus.rsa_rstb, bus.busy}); end
    total++; if (bus.res_status !== m_status) begin bad++; $display("FAIL %s status got=%b want=%b", name, bus.res_status, m_status); end
    total++; if (bus.res_c !== m_res_c) begin bad++; $display("FAIL %s res_c got=%0d want=%0d", name, bus.res_c, m_res_c); end
    total++; if (bus.res_owner !== m_res_owner) begin bad++; $display("FAIL %s owner got=%b want=%b", name, bus.res_owner, m_res_owner); end
    total++; if (bus.irq !== m_irq) begin bad++; $display("FAIL %s irq got=%b want=%b", name, bus.irq, m_irq); end

    step();  // back in IDLE
    bus.rsa_eoc = 1'b0; bus.irq_clr = 2'b00;
    if (clr_next) m_irq = m_irq & ~exp_rdy;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s idle_busy got=%b want=0", name, bus.busy); end
    total++; if ({bus.irq, bus.res_status} !== {m_irq, m_status}) begin bad++; $display("FAIL %s idle_irq_status got=%b want=%b", name, {bus.irq, bus.res_status}, {m_irq, m_status}); end
    bus.req_valid = 2'b00;
  endtask

  task automatic clear_irq(input logic [1:0] mask);
    bus.irq_clr = mask;
    step();
    bus.irq_clr = 2'b00;
    m_irq = m_irq & ~mask;
    total++; if (bus.irq !== m_irq) begin bad++; $display("FAIL irq_clear got=%b want=%b", bus.irq, m_irq); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rstb = 1'b1;
    #2 rstb = 1'b0;
    #1;
    total++; if ({bus.busy, bus.rsa_en, bus.rsa_rstb} !== 3'b000) begin bad++; $display("FAIL reset_ctl got=%b want=000", {bus.busy, bus.rsa_en, bus.rsa_rstb}); end
    total++; if ({bus.rsa_p, bus.rsa_e, bus.rsa_m, bus.rsa_const} !== '0) begin bad++; $display("FAIL reset_ops got=%h want=0", {bus.rsa_p, bus.rsa_e, bus.rsa_m, bus.rsa_const}); end
    total++; if (bus.res_c !== '0) begin bad++; $display("FAIL reset_res_c got=%0d want=0", bus.res_c); end
    total++; if ({bus.res_owner, bus.res_status, bus.irq} !== 5'b0) begin bad++; $display("FAIL reset_res got=%b want=00000", {bus.res_owner, bus.res_status, bus.irq}); end
    repeat (2) @(posedge clk);
    @(negedge clk) rstb = 1'b1;
    step();
    init_model();
    total++; if ({bus.busy, bus.req_ready} !== 3'b000) begin bad++; $display("FAIL reset_idle got=%b want=000", {bus.busy, bus.req_ready}); end
  endtask

  task automatic test_single_job();
    run_job("single", 2'b01, {8'd33, 8'd7, 8'd2, 8'd0}, (4*W)'($urandom), 8'd29, 10, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    run_job("abort", 2'b10, (4*W)'($urandom), (4*W)'($urandom), 8'd77, 0, 5, 3, 1'b0, 1'b0);
    total++; if (bus.res_c !== 8'd29) begin bad++; $display("FAIL abort_keeps_c got=%0d want=29", bus.res_c); end
  endtask

  task automatic test_timeout();
    run_job("timeout", 2'b01, (4*W)'($urandom), (4*W)'($urandom), 8'd0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_simultaneous();
    clear_irq(2'b11);
    run_job("abort_eoc_clr", 2'b01, (4*W)'($urandom), (4*W)'($urandom), 8'd55, 4, 4, 0, 1'b1, 1'b1);
  endtask

  task automatic test_enable();
    bus.ena = 1'b0; bus.req_valid = 2'b01;
    #1;
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL ena_ready got=%b want=00", bus.req_ready); end
    repeat (3) step();
    total++; if ({bus.busy, bus.req_ready} !== 3'b000) begin bad++; $display("FAIL ena_nogrant got=%b want=000", {bus.busy, bus.req_ready}); end
    bus.ena = 1'b1; bus.req_valid = 2'b00;
  endtask

  task automatic test_reset_mid_run();
    bus.req_valid = 2'b01; bus.req0_ops = (4*W)'($urandom);
    step();  // LOAD
    bus.req_valid = 2'b00;
    step(); step();  // RUN cycle 2
    total++; if (bus.rsa_en !== 1'b1) begin bad++; $display("FAIL midrun_started got=%b want=1", bus.rsa_en); end
    #2 rstb = 1'b0;
    #1;
    total++; if ({bus.busy, bus.rsa_en, bus.rsa_rstb} !== 3'b000) begin bad++; $display("FAIL midrun_ctl got=%b want=000", {bus.busy, bus.rsa_en, bus.rsa_rstb}); end
    total++; if ({bus.rsa_p, bus.rsa_e, bus.rsa_m, bus.rsa_const, bus.res_c} !== '0) begin bad++; $display("FAIL midrun_data got=%h want=0", {bus.rsa_p, bus.rsa_e, bus.rsa_m, bus.rsa_const, bus.res_c}); end
    total++; if ({bus.res_owner, bus.res_status, bus.irq} !== 5'b0) begin bad++; $display("FAIL midrun_res got=%b want=00000", {bus.res_owner, bus.res_status, bus.irq}); end
    @(negedge clk) rstb = 1'b1;
    step();
    init_model();
  endtask

  task automatic test_round_robin();
    for (int j = 0; j < 4; j++) begin
      run_job("rr", 2'b11, (4*W)'($urandom), (4*W)'($urandom), W'($urandom), 2 + j, 0, 0, 1'b0, 1'b0);
      if (j == 1) begin
        total++; if (bus.irq !== 2'b11) begin bad++; $display("FAIL rr_irq got=%b want=11", bus.irq); end
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 12; j++) begin
      run_job("rand", 2'($urandom_range(1, 3)), (4*W)'($urandom), (4*W)'($urandom), W'($urandom),
              int'($urandom_range(0, 20)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 20)) : 0,
              int'($urandom_range(0, 20)), 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_job();
    test_abort();
    test_timeout();
    test_simultaneous();
    test_enable();
    test_reset_mid_run();
    test_round_robin();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rsa_job_arbiter.md
# rsa_job_arbiter

Shares the single `rsa_unit` between two requesters: requester 0 is the SPI register file and requester 1 is the GPIO path. The block runs a round-robin arbiter and latches the winning requester's operands (P, E, M, Const). It then sequences the unit's reset/enable, guards each job with a timeout watchdog, captures the result C, and raises a sticky per-requester interrupt. It sits between `gpio_wrapper`/spireg and `rsa_unit`, and replaces ad-hoc start/stop gating at top level.

## Interface
Parameters:
- `WIDTH`, 8, operand/result width
- `TIMEOUT`, 1023, maximum cycles in RUN before abort (legal range 2..65535)

Ports:
- `clk`  in  1  system clock
- `rstb`  in  1  reset, asynchronous, active-low
- `ena`  in  1  design enable; low blocks new grants only
- `req_valid`  in  2  per-requester job request
- `req_ready`  out  2  per-requester grant; transfer on valid&ready at clk edge
- `req0_ops`, `req1_ops`  in  4*WIDTH  operands packed {P,E,M,Const}, P in MSBs
- `abort`  in  2  per-requester stop; honoured only for the current owner
- `irq_clr`  in  2  per-requester interrupt clear
- `rsa_en`  out  1  enable to `rsa_unit`
- `rsa_rstb`  out  1  active-low reset to `rsa_unit`
- `rsa_p`, `rsa_e`, `rsa_m`, `rsa_const`  out  WIDTH  registered operands
- `rsa_eoc`  in  1  end-of-computation from `rsa_unit`
- `rsa_c`  in  WIDTH  result from `rsa_unit`
- `res_c`  out  WIDTH  last captured result
- `res_owner`  out  1  requester of last finished job
- `res_status`  out  2  status of last finished job: 00 none, 01 done, 10 aborted, 11 timeout
- `irq`  out  2  sticky per-requester completion interrupt
- `busy`  out  1  high in every state except IDLE

## Operation
- FSM has four states: IDLE, LOAD, RUN, FLUSH.
- **IDLE**
  - `rsa_rstb`=0 and `rsa_en`=0.
  - Arbitration:
    - If `ena`=1 and exactly one `req_valid` bit is set, that requester wins.
    - If both bits are set, the requester other than `last_owner` wins.
  - `req_ready[winner]`=1 combinationally; the other bit is 0. `req_ready` is 0 in all other states and whenever `ena`=0.
  - On transfer:
    - latch the winner's ops into `rsa_*`;
    - set owner=winner and `last_owner`=winner;
    - go to LOAD.
- **LOAD** (1 cycle): `rsa_rstb`=1, `rsa_en`=0. Then go to RUN and clear the timer.
- **RUN**
  - `rsa_rstb`=1 and `rsa_en`=1; the timer increments each cycle.
  - Exit priority is abort, then eoc, then timeout:
    - `abort[owner]`: status 10, `res_c` unchanged.
    - `rsa_eoc`: `res_c` ← `rsa_c`, status 01.
    - timer==TIMEOUT-1: status 11, `res_c` unchanged.
  - On exit: `res_owner`←owner, `irq[owner]`←1, go to FLUSH.
  - `abort[!owner]` is ignored.
- **FLUSH** (1 cycle): `rsa_en`=0, `rsa_rstb`=0. Then go to IDLE.
- `irq[i]`
  - Cleared by `irq_clr[i]`.
  - If set and clear occur in the same cycle, set wins.
  - `irq_clr` has no other effect.
- `ena`=0 outside IDLE is ignored; the running job completes.
- Operand inputs are don't-care except in the transfer cycle. `rsa_*` operands hold their value until the next transfer.
- Reset (async, any state, including mid-job) forces:
  - state IDLE, `last_owner`=1 (requester 0 wins the first tie);
  - `rsa_en`=0, `rsa_rstb`=0;
  - `rsa_p`/`rsa_e`/`rsa_m`/`rsa_const`=0;
  - `res_c`=0, `res_owner`=0, `res_status`=00;
  - `irq`=00, `busy`=0, timer=0.
- The timer is ceil(log2(TIMEOUT)) bits wide and never wraps; it is cleared on LOAD→RUN.

## Timing
- Cycle T (IDLE): valid&ready sampled at the end of T. Cycle T+1: LOAD. Cycle T+2: first RUN cycle (`rsa_en`=1).
- eoc high in RUN cycle k → `res_c`/`res_status`/`irq` visible in cycle k+1 (FLUSH) → IDLE in k+2. The next grant is possible in k+2.
- Timeout: with no eoc, RUN lasts exactly TIMEOUT cycles, and FLUSH follows.
- `rsa_eoc` outside RUN is ignored.

## Test plan
- **Single job:** req0 ops {P=33,E=7,M=2,Const=0}, with a stub unit asserting eoc with C=29 in its 10th RUN cycle.
  - Response: `rsa_en` high for exactly 10 cycles, `res_c`=29, `res_status`=01, `res_owner`=0, `irq`=01, `busy` low 2 cycles after eoc.
- **Tie and round-robin:** after reset, both requesters are valid continuously.
  - Response: grants go 0,1,0,1; each `req_ready` pulse lasts 1 cycle; `irq` becomes 11 after two jobs.
- **Abort:** abort[1] during req1's 5th RUN cycle.
  - Response: status 10, `res_c` keeps its previous value (29), `irq[1]`=1.
  - abort[0] pulsed during req1's job has no effect.
- **Timeout:** TIMEOUT=16, the stub never asserts eoc.
  - Response: `rsa_en` high for exactly 16 cycles, then status 11 and `rsa_rstb` low.
- **Simultaneous events:**
  - abort and eoc in the same RUN cycle → status 10.
  - `irq_clr[0]` in the same cycle `irq[0]` sets → `irq[0]` stays 1.
  - `irq_clr[0]` one cycle later → `irq[0]`=0.
- **Enable and reset:**
  - With `ena`=0 and req0 valid → no grant and `req_ready`=00.
  - `rstb` asserted mid-RUN → all outputs at reset values immediately (asynchronously); after release, requester 0 wins the first tie.
